// File: rtl/alu_sequencer_pkg.sv
// Shared opcode values, FSM state encodings and flag layout for alu_sequencer.
package alu_sequencer_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [3:0] {
    OP_NOT = 4'h0,
    OP_XOR = 4'h1,
    OP_OR  = 4'h2,
    OP_AND = 4'h3,
    OP_SUB = 4'h4,
    OP_ADD = 4'h5,
    OP_RR  = 4'h6,
    OP_RL  = 4'h7,
    OP_DEC = 4'h8,
    OP_INC = 4'h9,
    OP_LD  = 4'hA,
    OP_ST  = 4'hB,
    OP_JMP = 4'hC,
    OP_JZ  = 4'hD,
    OP_JC  = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_FETCH2 = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  typedef struct packed {
    logic s;
    logic p;
    logic ov;
    logic cy;
    logic z;
  } flags_t;

  function automatic logic is_alu_op(input opcode_e op);
    return op <= OP_INC;
  endfunction

  function automatic logic is_jump(input opcode_e op);
    return (op == OP_JMP) || (op == OP_JZ) || (op == OP_JC);
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer driving an external ALU and register file.
// Define ALU_SEQ_JUMP_EN to enable two-word JMP/JZ/JC; otherwise they execute as NOPs.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [PC_W-1:0]   pmem_addr,
  output logic              pmem_rd,
  input  logic [DATA_W-1:0] pmem_data,
  output logic [3:0]        rf_addr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              rf_we,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [3:0]        alu_instr_code,
  output logic [DATA_W-1:0] alu_acc,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_z,
  input  logic              alu_cy,
  input  logic              alu_ov,
  input  logic              alu_p,
  input  logic              alu_s,
  output logic [4:0]        flags
);

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  state_e            state;
  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] acc;
  flags_t            flg;
  opcode_e           op;

  assign op             = opcode_e'(ir[7:4]);
  assign pmem_addr      = pc;
  assign rf_addr        = ir[3:0];
  assign alu_instr_code = ir[7:4];
  assign alu_acc        = acc;
  assign flags          = flg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      pc       <= '0;
      ir       <= '0;
      acc      <= '0;
      flg      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pmem_rd  <= 1'b0;
      rf_we    <= 1'b0;
      rf_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_FETCH;
            pmem_rd <= 1'b1;
            busy    <= 1'b1;
          end
        end
        S_FETCH: begin
          state   <= S_DECODE;
          pmem_rd <= 1'b0;
        end
        S_DECODE: begin
          ir    <= pmem_data;
          pc    <= pc + PC_ONE;
          state <= S_EXEC;
        end
        S_EXEC: begin
`ifdef ALU_SEQ_JUMP_EN
          // Jumps detour through FETCH2 to read their target word at the incremented pc
          if (is_jump(op)) begin
            state   <= S_FETCH2;
            pmem_rd <= 1'b1;
          end else
`endif
          begin
            state <= S_WB;
            if (op == OP_ST) begin
              rf_we    <= 1'b1;
              rf_wdata <= acc;
            end
          end
        end
        S_FETCH2: begin
          state   <= S_WB;
          pmem_rd <= 1'b0;
        end
        S_WB: begin
          rf_we <= 1'b0;
          if (is_alu_op(op)) begin
            acc   <= alu_result;
            flg.z <= alu_z;
            flg.p <= alu_p;
            flg.s <= alu_s;
            if (op == OP_ADD) begin
              flg.cy <= alu_cy;
              flg.ov <= alu_ov;
            end
          end else begin
            case (op)
              OP_LD:  acc <= rf_rdata;
`ifdef ALU_SEQ_JUMP_EN
              OP_JMP: pc <= pmem_data[PC_W-1:0];
              OP_JZ:  pc <= flg.z  ? pmem_data[PC_W-1:0] : pc + PC_ONE;
              OP_JC:  pc <= flg.cy ? pmem_data[PC_W-1:0] : pc + PC_ONE;
`endif
              default: ;
            endcase
          end
          if (op == OP_HLT) begin
            state <= S_HALT;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state   <= S_FETCH;
            pmem_rd <= 1'b1;
          end
        end
        S_HALT: begin
          if (start) begin
            pc      <= '0;
            acc     <= '0;
            flg     <= '0;
            state   <= S_FETCH;
            pmem_rd <= 1'b1;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with behavioural ALU, program memory and register file.
module tb_alu_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic start, start4;

  logic       busy, done, pmem_rd, rf_we;
  logic [7:0] pmem_addr;
  logic [7:0] pmem_q;
  logic [3:0] rf_addr, alu_instr_code;
  logic [7:0] rf_rdata, rf_wdata, alu_acc, alu_result;
  logic       alu_z, alu_cy, alu_ov, alu_p, alu_s;
  logic [4:0] flags;

  logic       busy4, done4, pmem_rd4, rf_we4;
  logic [3:0] pmem_addr4;
  logic [3:0] rf_addr4, alu_instr_code4;
  logic [7:0] rf_rdata4, rf_wdata4, alu_acc4, alu_result4;
  logic       alu_z4, alu_cy4, alu_ov4, alu_p4, alu_s4;
  logic [4:0] flags4;

  logic [7:0] pmem [256];
  logic [7:0] rf   [16];
  logic       ld_en;
  logic [3:0] ld_addr;
  logic [7:0] ld_val;
  int wr_count = 0;
  int overlap  = 0;
  int checks   = 0;
  int errors   = 0;

  always #5 clk = ~clk;

  function automatic logic [12:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] w;
    logic [7:0] r;
    logic c, v;
    w = '0; r = a; c = 1'b0; v = 1'b0;
    case (op)
      4'h0: r = ~a;
      4'h1: r = a ^ b;
      4'h2: r = a | b;
      4'h3: r = a & b;
      4'h4: begin w = {1'b0, a} - {1'b0, b}; r = w[7:0]; c = w[8]; v = (a[7] != b[7]) && (r[7] != a[7]); end
      4'h5: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
      4'h6: begin r = {a[0], a[7:1]}; c = a[0]; end
      4'h7: begin r = {a[6:0], a[7]}; c = a[7]; end
      4'h8: begin r = a - 8'd1; c = (a == 8'h00); end
      4'h9: begin r = a + 8'd1; c = (a == 8'hFF); end
      default: r = a;
    endcase
    return {r[7], ~^r, v, c, (r == 8'h00), r};
  endfunction

  assign {alu_s, alu_p, alu_ov, alu_cy, alu_z, alu_result} = alu_f(alu_instr_code, alu_acc, rf_rdata);
  assign {alu_s4, alu_p4, alu_ov4, alu_cy4, alu_z4, alu_result4} = alu_f(alu_instr_code4, alu_acc4, rf_rdata4);
  assign rf_rdata  = rf[rf_addr];
  assign rf_rdata4 = {4'h0, rf_addr4};

  always @(posedge clk) begin
    if (pmem_rd) pmem_q <= pmem[pmem_addr];
  end

  always @(posedge clk) begin
    if (ld_en) rf[ld_addr] <= ld_val;
    else if (rf_we) begin
      rf[rf_addr] <= rf_wdata;
      wr_count    <= wr_count + 1;
    end
  end

  always @(negedge clk) begin
    if ((pmem_rd && rf_we) || (pmem_rd4 && rf_we4)) overlap <= overlap + 1;
  end

  alu_sequencer #(.PC_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .pmem_addr(pmem_addr), .pmem_rd(pmem_rd), .pmem_data(pmem_q),
    .rf_addr(rf_addr), .rf_rdata(rf_rdata), .rf_we(rf_we), .rf_wdata(rf_wdata),
    .alu_instr_code(alu_instr_code), .alu_acc(alu_acc), .alu_result(alu_result),
    .alu_z(alu_z), .alu_cy(alu_cy), .alu_ov(alu_ov), .alu_p(alu_p), .alu_s(alu_s),
    .flags(flags)
  );

  // Sixteen-word program space of NOTs (pmem always reads 0x00)
  alu_sequencer #(.PC_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .busy(busy4), .done(done4),
    .pmem_addr(pmem_addr4), .pmem_rd(pmem_rd4), .pmem_data(8'h00),
    .rf_addr(rf_addr4), .rf_rdata(rf_rdata4), .rf_we(rf_we4), .rf_wdata(rf_wdata4),
    .alu_instr_code(alu_instr_code4), .alu_acc(alu_acc4), .alu_result(alu_result4),
    .alu_z(alu_z4), .alu_cy(alu_cy4), .alu_ov(alu_ov4), .alu_p(alu_p4), .alu_s(alu_s4),
    .flags(flags4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_rf(input logic [3:0] a, input logic [7:0] v);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_val = v;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  task automatic pulse_start;
    @(negedge clk);
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; start4 = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_val = '0;
    for (int i = 0; i < 256; i++) pmem[i] = 8'hF0;

    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pmem_rd", pmem_rd, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_alu_code", alu_instr_code, 0);
    chk("rst_acc", alu_acc, 0);
    chk("rst_flags", flags, 0);
    chk("rst_pmem_addr", pmem_addr, 0);
    #20;
    @(negedge clk) rst_n = 1'b1;
    step(2);
    chk("idle_no_fetch", pmem_rd, 0);

    // PC_W=4 wrap: 16 NOTs, second pass starts back at address 0
    @(negedge clk) start4 = 1'b1;
    step(1);
    start4 = 1'b0;
    chk("w4_busy", busy4, 1);
    chk("w4_addr0", pmem_addr4, 0);
    step(4);
    chk("w4_acc_1", alu_acc4, 8'hFF);
    chk("w4_addr1", pmem_addr4, 1);
    step(56);
    chk("w4_addr15", pmem_addr4, 4'hF);
    chk("w4_acc_15", alu_acc4, 8'hFF);
    step(4);
    chk("w4_wrap_addr", pmem_addr4, 0);
    chk("w4_wrap_rd", pmem_rd4, 1);
    chk("w4_acc_16", alu_acc4, 8'h00);
    chk("w4_flags", flags4, 5'b01001);
    chk("w4_done", done4, 0);
    chk("w4_rf_we", rf_we4, 0);
    chk("w4_rf_wdata", rf_wdata4, 0);
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;

    // LD r1, ADD r2, ST r3, HLT
    load_rf(4'd1, 8'h7F);
    load_rf(4'd2, 8'h81);
    load_rf(4'd3, 8'h55);
    load_rf(4'd5, 8'hFE);
    pmem[0] = 8'hA1; pmem[1] = 8'h52; pmem[2] = 8'hB3; pmem[3] = 8'hF0;
    pulse_start();
    chk("p1_busy", busy, 1);
    chk("p1_rd", pmem_rd, 1);
    chk("p1_addr", pmem_addr, 0);
    step(4);
    chk("p1_ld_acc", alu_acc, 8'h7F);
    chk("p1_ld_flags", flags, 0);
    chk("p1_addr1", pmem_addr, 1);
    step(4);
    chk("p1_add_acc", alu_acc, 8'h00);
    chk("p1_add_flags", flags, 5'b01011);
    start = 1'b1;
    step(3);
    start = 1'b0;
    chk("p1_st_we", rf_we, 1);
    chk("p1_st_wdata", rf_wdata, 8'h00);
    chk("p1_st_addr", rf_addr, 3);
    chk("p1_st_no_rd", pmem_rd, 0);
    step(1);
    chk("p1_st_we_off", rf_we, 0);
    chk("p1_addr3", pmem_addr, 3);
    step(3);
    chk("p1_done_early", done, 0);
    step(1);
    chk("p1_done", done, 1);
    chk("p1_busy_off", busy, 0);
    chk("p1_r3", rf[3], 8'h00);
    chk("p1_wr_count", wr_count, 1);
    chk("p1_flags_final", flags, 5'b01011);

    // LD r5 (0xFE), INC, INC, HLT: cy must hold despite ALU carry
    pmem[0] = 8'hA5; pmem[1] = 8'h90; pmem[2] = 8'h90; pmem[3] = 8'hF0;
    pulse_start();
    chk("p2_done_clr", done, 0);
    chk("p2_acc_clr", alu_acc, 0);
    chk("p2_flags_clr", flags, 0);
    chk("p2_addr", pmem_addr, 0);
    step(4);
    chk("p2_ld_acc", alu_acc, 8'hFE);
    step(4);
    chk("p2_inc1_acc", alu_acc, 8'hFF);
    chk("p2_inc1_flags", flags, 5'b11000);
    step(4);
    chk("p2_inc2_acc", alu_acc, 8'h00);
    chk("p2_inc2_flags", flags, 5'b01001);
    step(4);
    chk("p2_done", done, 1);

`ifdef ALU_SEQ_JUMP_EN
    // JZ taken at z=1 to 0x05, then JZ not taken at z=0
    pmem[0] = 8'hA1; pmem[1] = 8'h52; pmem[2] = 8'hD0; pmem[3] = 8'h05; pmem[4] = 8'hF0;
    pmem[5] = 8'h51; pmem[6] = 8'hD0; pmem[7] = 8'h0A; pmem[8] = 8'hF0;
    pulse_start();
    step(11);
    chk("j_fetch2_rd", pmem_rd, 1);
    chk("j_fetch2_addr", pmem_addr, 3);
    step(2);
    chk("j_taken_addr", pmem_addr, 5);
    chk("j_taken_rd", pmem_rd, 1);
    chk("j_taken_flags", flags, 5'b01011);
    step(4);
    chk("j_add_acc", alu_acc, 8'h7F);
    chk("j_add_flags", flags, 5'b00000);
    chk("j_addr6", pmem_addr, 6);
    step(5);
    chk("j_nt_addr", pmem_addr, 8);
    chk("j_nt_rd", pmem_rd, 1);
    step(4);
    chk("j_done", done, 1);
    chk("j_acc", alu_acc, 8'h7F);
`else
    // JMP at 0x03 behaves as a 4-cycle NOP
    pmem[0] = 8'hA1; pmem[1] = 8'h52; pmem[2] = 8'hA1; pmem[3] = 8'hC7; pmem[4] = 8'hF0;
    pulse_start();
    step(12);
    chk("n_addr3", pmem_addr, 3);
    chk("n_acc_before", alu_acc, 8'h7F);
    step(4);
    chk("n_next_addr", pmem_addr, 4);
    chk("n_next_rd", pmem_rd, 1);
    chk("n_acc", alu_acc, 8'h7F);
    chk("n_flags", flags, 5'b01011);
    step(4);
    chk("n_done", done, 1);
`endif

    // Reset during the cycle before ST write-back
    load_rf(4'd3, 8'hAA);
    pmem[0] = 8'hA1; pmem[1] = 8'hB3; pmem[2] = 8'hF0;
    pulse_start();
    step(6);
    chk("r_exec_we", rf_we, 0);
    chk("r_exec_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("r_busy", busy, 0);
    chk("r_done", done, 0);
    chk("r_rd", pmem_rd, 0);
    chk("r_we", rf_we, 0);
    chk("r_wdata", rf_wdata, 0);
    chk("r_code", alu_instr_code, 0);
    chk("r_acc", alu_acc, 0);
    chk("r_flags", flags, 0);
    chk("r_addr", pmem_addr, 0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    step(3);
    chk("r_idle_busy", busy, 0);
    chk("r_idle_rd", pmem_rd, 0);
    chk("r_r3_kept", rf[3], 8'hAA);
    chk("r_wr_count", wr_count, 1);
    chk("no_overlap", overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
